// File: rtl/layer_16_12_16_16.sv
// rtl/layer_16_12_16_16.sv - streaming fully-connected layer y = ReLU(W*x), 16 outputs from 12 inputs
// Weights come from the W_INIT image, row-major, W[0][0] in the least significant word.
module layer_16_12_16_16 #(
    parameter int T = 16,
    parameter int N = 16,
    parameter int M = 12,
    parameter int P = 16,
    parameter logic [T*N*M-1:0] W_INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    input  logic         m_ready,
    input  logic [T-1:0] data_in,
    output logic         m_valid,
    output logic         s_ready,
    output logic [T-1:0] data_out
);
    localparam int AW = 2*T + 4;
    localparam int CW = $clog2(M + 1);
    localparam int JW = $clog2(M);
    localparam int OW = $clog2(N);
    localparam logic [CW-1:0] IN_FULL = CW'(M);
    localparam logic [JW-1:0] J_LAST = JW'(M - 1);
    localparam logic [OW-1:0] O_LAST = OW'(N - 1);
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (T - 1)) - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, WAITOUT} state_t;

    state_t                 state;
    logic signed [T-1:0]    in_buf [M];
    logic [CW-1:0]          in_cnt;
    logic [JW-1:0]          j_cnt;
    logic signed [AW-1:0]   acc [P];
    logic [T-1:0]           out_buf [N];
    logic [OW-1:0]          out_idx;
    logic                   rst_done;

    logic signed [T-1:0]    w_rom [P][M];
    logic signed [2*T-1:0]  prod [P];
    logic signed [AW-1:0]   acc_next [P];
    logic                   in_fire, out_fire, out_free;

    function automatic logic [T-1:0] relu_sat(input logic signed [AW-1:0] a);
        if (a < 0)
            return '0;
        else if (a > SAT_MAX)
            return {1'b0, {(T-1){1'b1}}};
        else
            return a[T-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < P; i++)
            for (int j = 0; j < M; j++)
                w_rom[i][j] = W_INIT[(i*M + j)*T +: T];
    end

    // Every lane sees the same broadcast x[j_cnt] and its own row weight.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            prod[i]     = w_rom[i][j_cnt] * in_buf[j_cnt];
            acc_next[i] = acc[i] + {{(AW-2*T){prod[i][2*T-1]}}, prod[i]};
        end
    end

    assign s_ready  = rst_done && (in_cnt != IN_FULL);
    assign in_fire  = s_valid && s_ready;
    assign out_fire = m_valid && m_ready;
    assign out_free = !m_valid || (out_fire && out_idx == O_LAST);
    assign data_out = out_buf[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            in_cnt   <= '0;
            j_cnt    <= '0;
            out_idx  <= '0;
            m_valid  <= 1'b0;
            rst_done <= 1'b0;
            for (int k = 0; k < M; k++) in_buf[k] <= '0;
            for (int k = 0; k < P; k++) acc[k] <= '0;
            for (int k = 0; k < N; k++) out_buf[k] <= '0;
        end else begin
            rst_done <= 1'b1;
            if (in_fire) begin
                in_buf[in_cnt] <= data_in;
                in_cnt         <= in_cnt + 1'b1;
            end
            if (out_fire) begin
                for (int k = 0; k < N-1; k++) out_buf[k] <= out_buf[k+1];
                out_idx <= out_idx + 1'b1;
                if (out_idx == O_LAST)
                    m_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (in_cnt == IN_FULL) begin
                        if (out_free) begin
                            state <= COMPUTE;
                            j_cnt <= '0;
                            for (int k = 0; k < P; k++) acc[k] <= '0;
                        end else begin
                            state <= WAITOUT;
                        end
                    end
                end
                WAITOUT: begin
                    if (out_free) begin
                        state <= COMPUTE;
                        j_cnt <= '0;
                        for (int k = 0; k < P; k++) acc[k] <= '0;
                    end
                end
                COMPUTE: begin
                    for (int k = 0; k < P; k++) acc[k] <= acc_next[k];
                    j_cnt <= j_cnt + 1'b1;
                    // Compute only starts with the output side free, so the buffer is empty here.
                    if (j_cnt == J_LAST) begin
                        state   <= IDLE;
                        in_cnt  <= '0;
                        m_valid <= 1'b1;
                        out_idx <= '0;
                        for (int k = 0; k < N; k++) out_buf[k] <= relu_sat(acc_next[k]);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_16_12_16_16.sv
// tb/tb_layer_16_12_16_16.sv - scoreboard bench for layer_16_12_16_16 with three weight images
module tb_layer_16_12_16_16;
    localparam int T  = 16;
    localparam int N  = 16;
    localparam int M  = 12;
    localparam int WB = T*N*M;

    function automatic logic [WB-1:0] mk_w(input int kind);
        logic [WB-1:0] r;
        logic [T-1:0]  w;
        int            v;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                v = ((i*37 + j*91 + i*j*13) % 63) - 31;
                if (kind == 0)
                    w = (i == j) ? 16'd1 : 16'd0;
                else if (kind == 1)
                    w = 16'h7FFF;
                else
                    w = 16'(v);
                r[(i*M + j)*T +: T] = w;
            end
        end
        return r;
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid [3];
    logic        m_ready [3];
    logic        m_valid [3];
    logic        s_ready [3];
    logic [15:0] data_in [3];
    logic [15:0] data_out [3];

    logic [15:0] xq [$];
    logic [15:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        layer_16_12_16_16 #(.W_INIT(mk_w(g))) u_dut (
            .clk      (clk),
            .reset    (reset),
            .s_valid  (s_valid[g]),
            .m_ready  (m_ready[g]),
            .data_in  (data_in[g]),
            .m_valid  (m_valid[g]),
            .s_ready  (s_ready[g]),
            .data_out (data_out[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_y(input int d, input int i, input int base);
        logic [WB-1:0] wb;
        longint        acc;
        wb  = mk_w(d);
        acc = 0;
        for (int j = 0; j < M; j++)
            acc += longint'($signed(wb[(i*M + j)*T +: T])) * longint'($signed(xq[base + j]));
        if (acc < 0) return 16'h0000;
        if (acc > 32767) return 16'h7FFF;
        return acc[15:0];
    endfunction

    task automatic stream(input int d, input int pv, input int pr, input int budget,
                          input int hold, input bit lat_chk);
        int          nin, nout, cyc, t_acc, t_first, tot_in, tot_out;
        logic [15:0] e;
        nin = 0; nout = 0; cyc = 0; t_acc = -1; t_first = -1;
        tot_in  = xq.size();
        tot_out = (tot_in / M) * N;
        exp_q.delete();
        while ((nin < tot_in || nout < tot_out) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            s_valid[d] = (nin < tot_in) && (int'($urandom_range(99)) < pv);
            data_in[d] = s_valid[d] ? xq[nin] : 16'($urandom);
            m_ready[d] = (cyc > hold) && (int'($urandom_range(99)) < pr);
            if (hold > 0 && cyc == hold) begin
                chk("hold_s_ready", 32'(s_ready[d]), 32'd0);
                chk("hold_m_valid", 32'(m_valid[d]), 32'd1);
            end
            if (m_valid[d] && t_first < 0) t_first = cyc;
            if (s_valid[d] && s_ready[d]) begin
                nin++;
                if (nin % M == 0) begin
                    for (int i = 0; i < N; i++) exp_q.push_back(model_y(d, i, nin - M));
                    if (nin == tot_in) t_acc = cyc;
                end
            end
            if (m_valid[d] && m_ready[d]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(data_out[d]), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", 32'(data_out[d]), 32'(e));
                end
                nout++;
            end
        end
        @(negedge clk);
        s_valid[d] = 1'b0;
        chk("out_count", 32'(nout), 32'(tot_out));
        chk("exp_left", 32'(exp_q.size()), 32'd0);
        if (lat_chk)
            chk("latency_ok", 32'(t_first >= 0 && (t_first - t_acc - 1) <= M + 3), 32'd1);
        m_ready[d] = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_extra_out", 32'(m_valid[d]), 32'd0);
        m_ready[d] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_valid[k] = 1'b0;
            m_ready[k] = 1'b0;
            data_in[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid[0]), 32'd0);
        chk("rst_s_ready", 32'(s_ready[0]), 32'd0);
        chk("rst_data_out", 32'(data_out[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready[0]), 32'd1);

        // identity rows, x = 1..12
        xq.delete();
        for (int k = 0; k < M; k++) xq.push_back(16'(k + 1));
        stream(0, 100, 100, 200, 0, 1'b1);

        // identity rows, x = -1 clamps to zero
        xq.delete();
        for (int k = 0; k < M; k++) xq.push_back(16'hFFFF);
        stream(0, 100, 100, 200, 0, 1'b0);

        // all 7FFF weights and inputs saturate
        xq.delete();
        for (int k = 0; k < M; k++) xq.push_back(16'h7FFF);
        stream(1, 100, 100, 200, 0, 1'b1);

        // project weights, 833 vectors with random gaps on both sides
        xq.delete();
        for (int k = 0; k < 833*M; k++) xq.push_back(16'(int'($urandom_range(511)) - 256));
        stream(2, 50, 50, 80000, 0, 1'b0);

        // reset mid-vector, then one clean vector
        xq.delete();
        for (int k = 0; k < 5; k++) xq.push_back(16'(k * 7 + 3));
        stream(2, 100, 100, 100, 0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_m_valid", 32'(m_valid[2]), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready[2]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        xq.delete();
        for (int k = 0; k < M; k++) xq.push_back(16'(int'($urandom_range(511)) - 256));
        stream(2, 100, 100, 200, 0, 1'b0);

        // two vectors with outputs stalled for 100 cycles
        xq.delete();
        for (int k = 0; k < 2*M; k++) xq.push_back(16'(int'($urandom_range(511)) - 256));
        stream(2, 100, 100, 400, 100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
